register_bank_reader: RTL and testbench
=======================================

Name: register_bank_reader

Overview:
- Read-side initiator for the single-port mono register bank.
- On a start pulse, walks a contiguous window of bank entries through the bank's select/read-data interface.
- Streams each word out on a valid/ready interface, tagged with its index and a last flag.
- Used for register dumps, debug readout and context save; never writes the bank.

Parameters:
- DATA_WIDTH, 8, width of one bank entry and of o_data.
- NUM_REG, 6, number of bank entries.
- SELECT_WIDTH, $clog2(NUM_REG), localparam; width of the select and index buses.
- COUNT_WIDTH, $clog2(NUM_REG+1), localparam; width of the count input.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately, independent of clk.
- i_start  input  1  one-cycle request; sampled only in IDLE.
- i_base  input  SELECT_WIDTH  first entry to read; sampled with i_start.
- i_count  input  COUNT_WIDTH  number of entries to read; sampled with i_start.
- o_bank_select  output  SELECT_WIDTH  drives the bank select.
- i_bank_read_data  input  DATA_WIDTH  combinational read data from the bank.
- o_data  output  DATA_WIDTH  registered stream data.
- o_index  output  SELECT_WIDTH  bank index of o_data.
- o_valid  output  1  stream valid.
- i_ready  input  1  stream ready from the consumer.
- o_last  output  1  marks the final beat; qualified by o_valid.
- o_checksum_beat  output  1  marks the checksum beat (CHECKSUM_EN only).
- o_busy  output  1  high in any state other than IDLE.
- o_done  output  1  one-cycle pulse when a transfer completes.
- o_error  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (rst=0): state IDLE. All outputs 0: o_bank_select, o_data, o_index, o_valid, o_last, o_checksum_beat, o_busy, o_done, o_error. The internal pointer, remaining counter and checksum are also cleared.
- Reset mid-transfer: transfer aborted, no o_done. After rst returns to 1, the block sits in IDLE and waits for a new i_start.
- States: IDLE, READ, SEND, DONE.
- IDLE, i_start=1:
  - Range check is done at COUNT_WIDTH+1 bits: i_base + i_count > NUM_REG.
  - If out of range: o_error=1 for the next cycle, stay IDLE, no beats.
  - Else if i_count==0: go to DONE, no beats.
  - Else: latch pointer=i_base and remaining=i_count, go to READ.
- IDLE, i_start=0: hold.
- READ:
  - o_bank_select=pointer.
  - At the clock edge: o_data<=i_bank_read_data, o_index<=pointer, o_valid<=1, o_last<=(remaining==1); go to SEND.
- SEND:
  - o_data, o_index and o_last are held stable while o_valid=1 and i_ready=0.
  - On o_valid & i_ready: o_valid<=0, remaining--, pointer++.
  - Then go to DONE if this was the last beat, otherwise go to READ.
- DONE: o_done=1 for exactly one cycle, then return to IDLE.
- o_bank_select holds its last value outside READ. It is never out of range, because the request was range-checked at start.
- Latency:
  - i_start to first o_valid: 2 cycles.
  - Maximum throughput: one beat per 2 cycles (READ plus SEND).
  - Final handshake to o_done: 1 cycle.
- i_start while o_busy=1: ignored, no error.
- i_ready while o_valid=0: ignored.
- Pointer arithmetic is at SELECT_WIDTH bits; the range check guarantees it never wraps within a transfer.

Optional Feature:
- Macro: REGISTER_BANK_READER_CHECKSUM_EN.
- Defined:
  - A DATA_WIDTH XOR accumulator clears on an accepted i_start.
  - It XORs each word as it is captured in READ.
  - After the final data beat's handshake, a SEND beat with o_data=checksum, o_index=0 and o_checksum_beat=1 is issued.
  - o_last moves to the checksum beat; the data beats all carry o_last=0.
  - i_count==0 yields a single checksum beat of value 0.
- Not defined: no accumulator; o_checksum_beat is tied to 0.

Test Plan:
- Bank preloaded [0..5]={10,11,12,13,14,15} for all scenarios unless stated.
- i_base=1, i_count=3, i_ready=1 -> beats (11,idx1),(12,idx2),(13,idx3,last). First o_valid 2 cycles after i_start; o_done 1 cycle after the last handshake.
- i_base=0, i_count=2, i_ready low for 3 cycles on the first beat -> o_data=10, o_index=0 held stable for those 3 cycles; then 11 with last; exactly 2 handshakes.
- i_base=4, i_count=3 -> o_error pulse, no o_valid, o_busy stays 0. Then i_base=4, i_count=2 -> 14, then 15 with last.
- i_count=0 -> o_done pulse, no beats. Also: a second i_start during a transfer is ignored, and the first transfer completes unchanged.
- rst driven to 0 asynchronously during the second beat -> all outputs 0 immediately, no o_done. After release, i_base=5, i_count=1 -> single beat (15, last).
- With REGISTER_BANK_READER_CHECKSUM_EN, bank [0..2]={AA,BB,0F}, i_base=0, i_count=3 -> beats AA, BB, 0F, then 1E with o_checksum_beat=1 and last.

Source files
------------

// File: rtl/register_bank_reader_if.sv
// Stream/bank bundle between register_bank_reader and its environment.
// Latency: none, this is wiring only.
// Backpressure: o_valid/i_ready on the stream side; the bank side is combinational.
//
// Signals, from the reader's side:
//   request : i_start, i_base, i_count
//   bank    : o_bank_select -> i_bank_read_data
//   stream  : o_data, o_index, o_last, o_checksum_beat, o_valid <-> i_ready
//   status  : o_busy, o_done, o_error
interface register_bank_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REG    = 6
);
  localparam int SELECT_WIDTH = $clog2(NUM_REG);
  localparam int COUNT_WIDTH  = $clog2(NUM_REG + 1);

  logic                    i_start;
  logic [SELECT_WIDTH-1:0] i_base;
  logic [COUNT_WIDTH-1:0]  i_count;
  logic [SELECT_WIDTH-1:0] o_bank_select;
  logic [DATA_WIDTH-1:0]   i_bank_read_data;
  logic [DATA_WIDTH-1:0]   o_data;
  logic [SELECT_WIDTH-1:0] o_index;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_last;
  logic                    o_checksum_beat;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_error;

  modport master (
    input  i_start, i_base, i_count, i_bank_read_data, i_ready,
    output o_bank_select, o_data, o_index, o_valid, o_last, o_checksum_beat,
           o_busy, o_done, o_error
  );

  modport slave (
    output i_start, i_base, i_count, i_bank_read_data, i_ready,
    input  o_bank_select, o_data, o_index, o_valid, o_last, o_checksum_beat,
           o_busy, o_done, o_error
  );
endinterface

// File: rtl/register_bank_reader.sv
// Read-side initiator: on i_start walks bank[i_base +: i_count] and streams each word with its index.
// Latency: i_start to first o_valid 2 cycles; one beat per 2 cycles max; last handshake to o_done 1 cycle.
// Backpressure: a beat holds data/index/last stable until i_ready; the bank is not re-read meanwhile.
//
// Ports: clk, rst (async active-low), bus (register_bank_reader_if.master).
// Optional feature: REGISTER_BANK_READER_CHECKSUM_EN appends an XOR checksum beat
// carrying o_last and o_checksum_beat; without it o_checksum_beat is tied to 0.
module register_bank_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REG    = 6
) (
  input logic                     clk,
  input logic                     rst,
  register_bank_reader_if.master  bus
);
  localparam int SELECT_WIDTH = $clog2(NUM_REG);
  localparam int COUNT_WIDTH  = $clog2(NUM_REG + 1);
  localparam int RANGE_WIDTH  = COUNT_WIDTH + 1;
`ifdef REGISTER_BANK_READER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t                  state, state_nxt;
  logic [SELECT_WIDTH-1:0] pointer, select_q, index_q;
  logic [COUNT_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    valid_q, last_q, error_q;
  logic [RANGE_WIDTH-1:0]  range_sum;
  logic                    out_of_range, accept, handshake, final_data;
  logic                    csum_beat;
  logic [DATA_WIDTH-1:0]   csum_acc;

  // One extra bit so base+count cannot wrap before the compare.
  assign range_sum    = RANGE_WIDTH'(bus.i_base) + RANGE_WIDTH'(bus.i_count);
  assign out_of_range = range_sum > RANGE_WIDTH'(NUM_REG);
  assign accept       = (state == IDLE) && bus.i_start && !out_of_range;
  assign handshake    = (state == SEND) && valid_q && bus.i_ready;
  assign final_data   = (remaining == COUNT_WIDTH'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
              if (bus.i_count == '0) state_nxt = CSUM_EN ? SEND : DONE;
              else                   state_nxt = READ;
            end
      READ: state_nxt = SEND;
      SEND: if (handshake) begin
              if (csum_beat)       state_nxt = DONE;
              else if (final_data) state_nxt = CSUM_EN ? SEND : DONE;
              else                 state_nxt = READ;
            end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pointer   <= '0;
      select_q  <= '0;
      remaining <= '0;
      data_q    <= '0;
      index_q   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      error_q <= (state == IDLE) && bus.i_start && out_of_range;
      case (state)
        IDLE: if (accept) begin
                pointer   <= bus.i_base;
                remaining <= bus.i_count;
                // Empty window with checksum: go straight to a zero checksum beat.
                if (CSUM_EN && bus.i_count == '0) begin
                  data_q  <= '0;
                  index_q <= '0;
                  valid_q <= 1'b1;
                  last_q  <= 1'b1;
                end
              end
        READ: begin
                data_q   <= bus.i_bank_read_data;
                index_q  <= pointer;
                select_q <= pointer;
                valid_q  <= 1'b1;
                last_q   <= !CSUM_EN && final_data;
              end
        SEND: if (handshake) begin
                valid_q <= 1'b0;
                if (!csum_beat) begin
                  remaining <= remaining - COUNT_WIDTH'(1);
                  pointer   <= pointer + SELECT_WIDTH'(1);
                  if (CSUM_EN && final_data) begin
                    data_q  <= csum_acc;
                    index_q <= '0;
                    valid_q <= 1'b1;
                    last_q  <= 1'b1;
                  end
                end
              end
        default: ;
      endcase
    end
  end

`ifdef REGISTER_BANK_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_acc  <= '0;
      csum_beat <= 1'b0;
    end else if (accept) begin
      csum_acc  <= '0;
      csum_beat <= (bus.i_count == '0);
    end else if (state == READ) begin
      csum_acc  <= csum_acc ^ bus.i_bank_read_data;
    end else if (handshake) begin
      // Flag rises as the last data beat retires and drops when the checksum beat retires.
      csum_beat <= !csum_beat && final_data;
    end
  end
`else
  assign csum_acc  = '0;
  assign csum_beat = 1'b0;
`endif

  // The select tracks the pointer only while reading, so it never shows the
  // post-increment pointer (which can equal NUM_REG after the last beat).
  assign bus.o_bank_select   = (state == READ) ? pointer : select_q;
  assign bus.o_data          = data_q;
  assign bus.o_index         = index_q;
  assign bus.o_valid         = valid_q;
  assign bus.o_last          = last_q;
  assign bus.o_checksum_beat = csum_beat;
  assign bus.o_busy          = (state != IDLE);
  assign bus.o_done          = (state == DONE);
  assign bus.o_error         = error_q;
endmodule

// File: tb/tb_register_bank_reader.sv
// Directed bench for register_bank_reader: bank model, handshake counter, immediate assertions.
// Latency and backpressure behaviour are checked cycle by cycle.
// Checksum scenario runs only when REGISTER_BANK_READER_CHECKSUM_EN is defined.
module tb_register_bank_reader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   hs_count = 0;
  logic [7:0] bank [0:7];

  register_bank_reader_if #(.DATA_WIDTH(8), .NUM_REG(6)) bus ();

  register_bank_reader #(.DATA_WIDTH(8), .NUM_REG(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.i_bank_read_data = bank[bus.o_bank_select];

  always @(posedge clk) if (bus.o_valid && bus.i_ready) hs_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sel"},   32'(bus.o_bank_select), 0);
    chk({tag, "_data"},  32'(bus.o_data), 0);
    chk({tag, "_index"}, 32'(bus.o_index), 0);
    chk({tag, "_valid"}, 32'(bus.o_valid), 0);
    chk({tag, "_last"},  32'(bus.o_last), 0);
    chk({tag, "_csum"},  32'(bus.o_checksum_beat), 0);
    chk({tag, "_busy"},  32'(bus.o_busy), 0);
    chk({tag, "_done"},  32'(bus.o_done), 0);
    chk({tag, "_error"}, 32'(bus.o_error), 0);
  endtask

  task automatic start(input int base, input int count);
    bus.i_start = 1'b1;
    bus.i_base  = 3'(base);
    bus.i_count = 3'(count);
    step();
    bus.i_start = 1'b0;
  endtask

  // Waits (bounded) for a beat, checks it, then retires it with i_ready=1.
  task automatic expect_beat(input string tag, input int d, input int idx, input int last, input int cs);
    int n = 0;
    bus.i_ready = 1'b1;
    while (!bus.o_valid && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.o_valid), 1);
    chk({tag, "_data"},  32'(bus.o_data), 32'(d));
    chk({tag, "_index"}, 32'(bus.o_index), 32'(idx));
    chk({tag, "_last"},  32'(bus.o_last), 32'(last));
    chk({tag, "_csum"},  32'(bus.o_checksum_beat), 32'(cs));
    step();
  endtask

  initial begin
    int hs_base;
    for (int i = 0; i < 8; i++) bank[i] = 8'(10 + i);
    bus.i_start = 1'b0;
    bus.i_base  = '0;
    bus.i_count = '0;
    bus.i_ready = 1'b0;

    #1;
    chk_idle_outputs("rst_async");
    step();
    step();
    chk_idle_outputs("rst_hold");
    rst = 1'b1;
    step();
    chk_idle_outputs("post_rst");

`ifdef REGISTER_BANK_READER_CHECKSUM_EN
    bank[0] = 8'hAA;
    bank[1] = 8'hBB;
    bank[2] = 8'h0F;
    start(0, 3);
    expect_beat("cs_b0", 'hAA, 0, 0, 0);
    expect_beat("cs_b1", 'hBB, 1, 0, 0);
    expect_beat("cs_b2", 'h0F, 2, 0, 0);
    expect_beat("cs_sum", 'h1E, 0, 1, 1);
    chk("cs_done", 32'(bus.o_done), 1);
    step();
    start(3, 0);
    expect_beat("cs_empty", 0, 0, 1, 1);
    chk("cs_empty_done", 32'(bus.o_done), 1);
    step();
    chk("cs_idle", 32'(bus.o_busy), 0);
`else
    // Window 1..3 at full throughput with exact cycle timing.
    bus.i_ready = 1'b1;
    start(1, 3);
    chk("s1_read_busy",  32'(bus.o_busy), 1);
    chk("s1_read_valid", 32'(bus.o_valid), 0);
    chk("s1_read_sel",   32'(bus.o_bank_select), 1);
    step();
    chk("s1_b0_valid", 32'(bus.o_valid), 1);
    chk("s1_b0_data",  32'(bus.o_data), 11);
    chk("s1_b0_index", 32'(bus.o_index), 1);
    chk("s1_b0_last",  32'(bus.o_last), 0);
    step();
    chk("s1_gap_valid", 32'(bus.o_valid), 0);
    chk("s1_gap_sel",   32'(bus.o_bank_select), 2);
    step();
    chk("s1_b1_data",  32'(bus.o_data), 12);
    chk("s1_b1_index", 32'(bus.o_index), 2);
    chk("s1_b1_last",  32'(bus.o_last), 0);
    step();
    step();
    chk("s1_b2_valid", 32'(bus.o_valid), 1);
    chk("s1_b2_data",  32'(bus.o_data), 13);
    chk("s1_b2_index", 32'(bus.o_index), 3);
    chk("s1_b2_last",  32'(bus.o_last), 1);
    step();
    chk("s1_done",      32'(bus.o_done), 1);
    chk("s1_done_busy", 32'(bus.o_busy), 1);
    chk("s1_done_sel",  32'(bus.o_bank_select), 3);
    step();
    chk("s1_done_pulse", 32'(bus.o_done), 0);
    chk("s1_idle_busy",  32'(bus.o_busy), 0);

    // Backpressure on the first beat for 3 cycles.
    hs_base = hs_count;
    bus.i_ready = 1'b0;
    start(0, 2);
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s2_hold%0d_valid", i), 32'(bus.o_valid), 1);
      chk($sformatf("s2_hold%0d_data", i),  32'(bus.o_data), 10);
      chk($sformatf("s2_hold%0d_index", i), 32'(bus.o_index), 0);
      step();
    end
    expect_beat("s2_b0", 10, 0, 0, 0);
    expect_beat("s2_b1", 11, 1, 1, 0);
    chk("s2_done", 32'(bus.o_done), 1);
    chk("s2_handshakes", 32'(hs_count - hs_base), 2);
    step();

    // Out-of-range request, then the largest legal window at the top.
    start(4, 3);
    chk("s3_error", 32'(bus.o_error), 1);
    chk("s3_busy",  32'(bus.o_busy), 0);
    chk("s3_valid", 32'(bus.o_valid), 0);
    step();
    chk("s3_error_pulse", 32'(bus.o_error), 0);
    chk("s3_idle_valid",  32'(bus.o_valid), 0);
    start(4, 2);
    chk("s3_ok_error", 32'(bus.o_error), 0);
    expect_beat("s3_b0", 14, 4, 0, 0);
    expect_beat("s3_b1", 15, 5, 1, 0);
    chk("s3_done", 32'(bus.o_done), 1);
    step();

    // Empty window.
    hs_base = hs_count;
    start(2, 0);
    chk("s4_done",  32'(bus.o_done), 1);
    chk("s4_valid", 32'(bus.o_valid), 0);
    step();
    chk("s4_done_pulse", 32'(bus.o_done), 0);
    chk("s4_busy",       32'(bus.o_busy), 0);
    chk("s4_no_beats",   32'(hs_count - hs_base), 0);

    // Start during a transfer is ignored.
    start(1, 2);
    bus.i_start = 1'b1;
    bus.i_base  = 3'd0;
    bus.i_count = 3'd1;
    step();
    bus.i_start = 1'b0;
    chk("s4_ign_error", 32'(bus.o_error), 0);
    expect_beat("s4_b0", 11, 1, 0, 0);
    expect_beat("s4_b1", 12, 2, 1, 0);
    chk("s4_ign_done", 32'(bus.o_done), 1);
    step();

    // Asynchronous reset during the second beat.
    start(0, 3);
    expect_beat("s5_b0", 10, 0, 0, 0);
    step();
    chk("s5_b1_valid", 32'(bus.o_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_idle_outputs("s5_rst");
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("s5_rst%0d_done", i), 32'(bus.o_done), 0);
    end
    rst = 1'b1;
    step();
    chk("s5_rel_busy", 32'(bus.o_busy), 0);
    chk("s5_rel_done", 32'(bus.o_done), 0);
    start(5, 1);
    expect_beat("s5_single", 15, 5, 1, 0);
    chk("s5_done", 32'(bus.o_done), 1);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
